// File: rtl/calc_key_sequencer.sv
// Key sequencer for the two-operand signed add/subtract calculator: synchronises the
// active-low key strobe, runs the power/entry/result FSM and produces a registered signed result.
module calc_key_sequencer #(
  parameter int unsigned DIGIT_MAX = 9,
  parameter int unsigned MAG_W     = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             validate,
  input  logic [7:0]       data,
  output logic             is_on,
  output logic [1:0]       edit_sel,
  output logic [MAG_W-1:0] out_A,
  output logic [MAG_W-1:0] out_B,
  output logic             sign_a,
  output logic             sign_b,
  output logic [MAG_W-1:0] value,
  output logic             signalR,
  output logic             result_valid,
  output logic             err
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_EDIT_A = 3'd1;
  localparam logic [2:0] ST_EDIT_B = 3'd2;
  localparam logic [2:0] ST_CALC   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  localparam logic [7:0] KEY_ON_OFF    = 8'd18;
  localparam logic [7:0] KEY_DEF_A     = 8'd15;
  localparam logic [7:0] KEY_DEF_B     = 8'd19;
  localparam logic [7:0] KEY_CLEAR_ALL = 8'd16;
  localparam logic [7:0] KEY_CHG_SIGN  = 8'd12;
  localparam logic [7:0] KEY_SUM       = 8'd26;
  localparam logic [7:0] KEY_MINUS     = 8'd30;
  localparam logic [7:0] DIGIT_TOP     = 8'(DIGIT_MAX);

  logic                    s1, s2, s3;
  logic                    warm, armed;
  logic                    key_evt;
  logic                    op_sub;
  logic [2:0]              state;
  logic signed [MAG_W:0]   sa, sb, r;
  logic [MAG_W-1:0]        r_mag;

  function automatic logic [MAG_W-1:0] shift_in(input logic [MAG_W-1:0] mag,
                                                input logic [7:0]       d);
    logic [MAG_W-1:0] keep;
    keep = mag % MAG_W'(10);
    return keep * MAG_W'(10) + MAG_W'(d);
  endfunction

  // The flops all reset to 1, which alone would fake a falling edge if validate is held
  // low through reset; events are only accepted once a real post-reset high has been seen.
  always_comb key_evt = armed & s3 & ~s2;

  always_comb begin
    sa = $signed({1'b0, out_A});
    sb = $signed({1'b0, out_B});
    if (sign_a) sa = -sa;
    if (sign_b) sb = -sb;
    r     = op_sub ? (sa - sb) : (sa + sb);
    r_mag = MAG_W'(r[MAG_W] ? -r : r);
  end

  always_comb begin
    is_on    = (state != ST_OFF);
    edit_sel = 2'd0;
    if (state == ST_EDIT_A) edit_sel = 2'd1;
    if (state == ST_EDIT_B) edit_sel = 2'd2;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1           <= 1'b1;
      s2           <= 1'b1;
      s3           <= 1'b1;
      warm         <= 1'b0;
      armed        <= 1'b0;
      state        <= ST_OFF;
      out_A        <= '0;
      out_B        <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      value        <= '0;
      signalR      <= 1'b0;
      result_valid <= 1'b0;
      op_sub       <= 1'b0;
      err          <= 1'b0;
    end else begin
      s1    <= validate;
      s2    <= s1;
      s3    <= s2;
      warm  <= 1'b1;
      armed <= armed | (warm & s1);
      err   <= 1'b0;
      case (state)
        ST_OFF: begin
          if (key_evt && data == KEY_ON_OFF) state <= ST_EDIT_A;
        end
        ST_CALC: begin
          value        <= r_mag;
          signalR      <= r[MAG_W];
          result_valid <= 1'b1;
          state        <= ST_RESULT;
        end
        ST_EDIT_A, ST_EDIT_B, ST_RESULT: begin
          if (key_evt) begin
            if (data <= DIGIT_TOP) begin
              if (state == ST_EDIT_A) out_A <= shift_in(out_A, data);
              if (state == ST_EDIT_B) out_B <= shift_in(out_B, data);
            end else begin
              case (data)
                KEY_ON_OFF: begin
                  state        <= ST_OFF;
                  out_A        <= '0;
                  out_B        <= '0;
                  sign_a       <= 1'b0;
                  sign_b       <= 1'b0;
                  value        <= '0;
                  signalR      <= 1'b0;
                  result_valid <= 1'b0;
                  op_sub       <= 1'b0;
                end
                KEY_DEF_A: begin
                  out_A        <= '0;
                  sign_a       <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= ST_EDIT_A;
                end
                KEY_DEF_B: begin
                  out_B        <= '0;
                  sign_b       <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= ST_EDIT_B;
                end
                KEY_CLEAR_ALL: begin
                  out_A        <= '0;
                  out_B        <= '0;
                  sign_a       <= 1'b0;
                  sign_b       <= 1'b0;
                  value        <= '0;
                  signalR      <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= ST_EDIT_A;
                end
                KEY_CHG_SIGN: begin
                  if (state == ST_EDIT_A) sign_a <= ~sign_a;
                  if (state == ST_EDIT_B) sign_b <= ~sign_b;
                end
                KEY_SUM, KEY_MINUS: begin
                  op_sub       <= (data == KEY_MINUS);
                  result_valid <= 1'b0;
                  state        <= ST_CALC;
                end
                default: err <= 1'b1;
              endcase
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule
